// File: rtl/axi_slave_write_ctrl_if.sv
// +-----------------------------------------------------------------------+
// | axi_slave_write_ctrl_if : AXI3 AW/W/B channel bundle                  |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

interface axi_slave_write_ctrl_if #(
  parameter int WIDTH = 32,
  parameter int SIZE  = 3,
  parameter int ID_W  = 4
);
  localparam int c_nb = WIDTH / 8;

  logic [ID_W-1:0]  AWID;
  logic [31:0]      AWADDR;
  logic [3:0]       AWLEN;
  logic [SIZE-1:0]  AWSIZE;
  logic [1:0]       AWBURST;
  logic             AWVALID;
  logic             AWREADY;

  logic [ID_W-1:0]  WID;
  logic [WIDTH-1:0] WDATA;
  logic [c_nb-1:0]  WSTRB;
  logic             WLAST;
  logic             WVALID;
  logic             WREADY;

  logic [ID_W-1:0]  BID;
  logic [1:0]       BRESP;
  logic             BVALID;
  logic             BREADY;

  modport master (
    output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
    output WID, WDATA, WSTRB, WLAST, WVALID,
    output BREADY,
    input  AWREADY, WREADY, BID, BRESP, BVALID
  );

  modport slave (
    input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
    input  WID, WDATA, WSTRB, WLAST, WVALID,
    input  BREADY,
    output AWREADY, WREADY, BID, BRESP, BVALID
  );
endinterface

`default_nettype wire

// File: rtl/axi_slave_write_ctrl.sv
// +-----------------------------------------------------------------------+
// | axi_slave_write_ctrl : AXI3 write slave into a byte-addressed memory  |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

module axi_slave_write_ctrl #(
  parameter int WIDTH     = 32,
  parameter int SIZE      = 3,
  parameter int ID_W      = 4,
  parameter int MEM_BYTES = 4096
) (
  input  logic                        clk,
  input  logic                        resetn,
  axi_slave_write_ctrl_if.slave       bus,
  output logic [MEM_BYTES-1:0][7:0]   slave_mem
);

  localparam int              c_nb        = WIDTH / 8;
  localparam int              c_nb_log2   = $clog2(c_nb);
  localparam int              c_ma_w      = $clog2(MEM_BYTES);
  localparam logic [31:0]     c_lane_mask = 32'(c_nb - 1);
  localparam logic [SIZE-1:0] c_max_size  = SIZE'(c_nb_log2);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              awready_q, awready_d;
  logic              wready_q, wready_d;
  logic              bvalid_q, bvalid_d;
  logic [ID_W-1:0]   bid_q, bid_d;
  logic [1:0]        bresp_q, bresp_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [31:0]       addr_q, addr_d;
  logic [3:0]        len_q, len_d;
  logic [SIZE-1:0]   size_q, size_d;
  logic [1:0]        burst_q, burst_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              over_q, over_d;
  logic              err_q, err_d;
  logic              discard_q, discard_d;
  logic [MEM_BYTES-1:0][7:0] mem_q;

  logic [31:0]       s_bytes, wrap_span, wrap_base, beat_off, beat_addr;
  logic [31:0]       lane_lo, lane_hi, lane_base, aw_align;
  logic              w_hs, aw_err, beat_err;
  logic [c_nb-1:0]   lane_we;
  logic [c_nb-1:0][c_ma_w-1:0] lane_addr;

  // Beat address and the byte lanes it is allowed to touch.
  always_comb begin
    s_bytes   = 32'd1 << size_q;
    wrap_span = s_bytes * (32'(len_q) + 32'd1);
    beat_off  = 32'(cnt_q) * s_bytes;
    wrap_base = addr_q & ~(wrap_span - 32'd1);
    case (burst_q)
      2'b00:   beat_addr = addr_q;
      2'b10:   beat_addr = wrap_base + ((addr_q - wrap_base + beat_off) & (wrap_span - 32'd1));
      default: beat_addr = (cnt_q == 4'd0) ? addr_q : (addr_q & ~(s_bytes - 32'd1)) + beat_off;
    endcase
    lane_lo   = beat_addr & c_lane_mask;
    lane_hi   = ((beat_addr & ~(s_bytes - 32'd1)) & c_lane_mask) + s_bytes;
    lane_base = beat_addr & ~c_lane_mask;
    w_hs      = bus.WVALID && wready_q;
    for (int k = 0; k < c_nb; k++) begin
      lane_we[k]   = w_hs && !discard_q && !over_q && bus.WSTRB[k] &&
                     (32'(k) >= lane_lo) && (32'(k) < lane_hi);
      lane_addr[k] = c_ma_w'(lane_base + 32'(k));
    end
  end

  always_comb begin
    state_d   = state_q;
    awready_d = awready_q;
    wready_d  = wready_q;
    bvalid_d  = bvalid_q;
    bid_d     = bid_q;
    bresp_d   = bresp_q;
    id_d      = id_q;
    addr_d    = addr_q;
    len_d     = len_q;
    size_d    = size_q;
    burst_d   = burst_q;
    cnt_d     = cnt_q;
    over_d    = over_q;
    err_d     = err_q;
    discard_d = discard_q;

    aw_align = bus.AWADDR & ((32'd1 << bus.AWSIZE) - 32'd1);
    aw_err   = (bus.AWBURST == 2'b11) || (bus.AWSIZE > c_max_size) ||
               ((bus.AWBURST == 2'b10) &&
                (!(bus.AWLEN == 4'd1 || bus.AWLEN == 4'd3 || bus.AWLEN == 4'd7 ||
                   bus.AWLEN == 4'd15) || (aw_align != 32'd0)));
    // Once saturated, cnt_q == len_q, so trailing beats never flag an early WLAST.
    beat_err = (bus.WID != id_q) ||
               (bus.WLAST && (cnt_q != len_q)) ||
               (!bus.WLAST && (cnt_q == len_q));

    case (state_q)
      IDLE: begin
        if (bus.AWVALID && awready_q) begin
          id_d      = bus.AWID;
          addr_d    = bus.AWADDR;
          len_d     = bus.AWLEN;
          size_d    = bus.AWSIZE;
          burst_d   = bus.AWBURST;
          cnt_d     = 4'd0;
          over_d    = 1'b0;
          err_d     = aw_err;
          discard_d = aw_err;
          awready_d = 1'b0;
          wready_d  = 1'b1;
          state_d   = DATA;
        end
      end
      DATA: begin
        if (w_hs) begin
          err_d = err_q || beat_err;
          if (cnt_q == len_q) begin
            over_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
          if (bus.WLAST) begin
            wready_d = 1'b0;
            bvalid_d = 1'b1;
            bid_d    = id_q;
            bresp_d  = err_d ? 2'b10 : 2'b00;
            state_d  = RESP;
          end
        end
      end
      RESP: begin
        if (bvalid_q && bus.BREADY) begin
          bvalid_d  = 1'b0;
          awready_d = 1'b1;
          state_d   = IDLE;
        end
      end
      default: begin
        state_d   = IDLE;
        awready_d = 1'b1;
        wready_d  = 1'b0;
        bvalid_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      awready_q <= 1'b1;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bid_q     <= '0;
      bresp_q   <= 2'b00;
      id_q      <= '0;
      addr_q    <= '0;
      len_q     <= '0;
      size_q    <= '0;
      burst_q   <= '0;
      cnt_q     <= '0;
      over_q    <= 1'b0;
      err_q     <= 1'b0;
      discard_q <= 1'b0;
      mem_q     <= '0;
    end else begin
      state_q   <= state_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bid_q     <= bid_d;
      bresp_q   <= bresp_d;
      id_q      <= id_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      size_q    <= size_d;
      burst_q   <= burst_d;
      cnt_q     <= cnt_d;
      over_q    <= over_d;
      err_q     <= err_d;
      discard_q <= discard_d;
      for (int k = 0; k < c_nb; k++) begin
        if (lane_we[k]) begin
          mem_q[lane_addr[k]] <= bus.WDATA[8*k +: 8];
        end
      end
    end
  end

  assign bus.AWREADY = awready_q;
  assign bus.WREADY  = wready_q;
  assign bus.BVALID  = bvalid_q;
  assign bus.BID     = bid_q;
  assign bus.BRESP   = bresp_q;
  assign slave_mem   = mem_q;

endmodule

`default_nettype wire

// File: tb/tb_axi_slave_write_ctrl.sv
// +-----------------------------------------------------------------------+
// | tb_axi_slave_write_ctrl : directed bench for the AXI3 write slave     |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_axi_slave_write_ctrl;
  localparam int WIDTH     = 32;
  localparam int SIZE      = 3;
  localparam int ID_W      = 4;
  localparam int MEM_BYTES = 4096;

  logic clk;
  logic resetn;
  logic [MEM_BYTES-1:0][7:0] slave_mem;
  logic [MEM_BYTES-1:0][7:0] exp_mem;
  int errors = 0;
  int checks = 0;

  axi_slave_write_ctrl_if #(.WIDTH(WIDTH), .SIZE(SIZE), .ID_W(ID_W)) bus ();

  axi_slave_write_ctrl #(
    .WIDTH(WIDTH), .SIZE(SIZE), .ID_W(ID_W), .MEM_BYTES(MEM_BYTES)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .bus(bus),
    .slave_mem(slave_mem)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic int first_diff();
    for (int i = 0; i < MEM_BYTES; i++)
      if (slave_mem[i] !== exp_mem[i]) return i;
    return 0;
  endfunction

  task automatic set_word(input logic [31:0] a, input logic [31:0] d);
    for (int k = 0; k < 4; k++) exp_mem[12'(a + 32'(k))] = d[8*k +: 8];
  endtask

  task automatic do_aw(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                       input logic [2:0] size, input logic [1:0] burst);
    int n;
    bus.AWID = id; bus.AWADDR = addr; bus.AWLEN = len; bus.AWSIZE = size;
    bus.AWBURST = burst; bus.AWVALID = 1'b1;
    n = 0;
    while (bus.AWREADY !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    if (n >= 20) begin
      checks++; errors++;
      $display("FAIL aw_timeout: AWREADY got 0 required 1");
    end
    @(posedge clk); #1;
    bus.AWVALID = 1'b0;
  endtask

  task automatic do_w(input logic [3:0] id, input logic [31:0] data, input logic [3:0] strb,
                      input logic last);
    int n;
    bus.WID = id; bus.WDATA = data; bus.WSTRB = strb; bus.WLAST = last; bus.WVALID = 1'b1;
    n = 0;
    while (bus.WREADY !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    if (n >= 20) begin
      checks++; errors++;
      $display("FAIL w_timeout: WREADY got 0 required 1");
    end
    @(posedge clk); #1;
  endtask

  task automatic w_idle();
    bus.WVALID = 1'b0; bus.WLAST = 1'b0;
  endtask

  task automatic do_b(output logic [3:0] bid, output logic [1:0] bresp);
    int n;
    n = 0;
    while (bus.BVALID !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    if (n >= 20) begin
      checks++; errors++;
      $display("FAIL b_timeout: BVALID got 0 required 1");
    end
    bid = bus.BID; bresp = bus.BRESP;
    bus.BREADY = 1'b1;
    @(posedge clk); #1;
    bus.BREADY = 1'b0;
  endtask

  task automatic test_reset();
    int idx;
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.AWREADY !== 1'b1) begin errors++; $display("FAIL reset_awready: got %b required 1", bus.AWREADY); end
    checks++; if (bus.WREADY !== 1'b0) begin errors++; $display("FAIL reset_wready: got %b required 0", bus.WREADY); end
    checks++; if (bus.BVALID !== 1'b0) begin errors++; $display("FAIL reset_bvalid: got %b required 0", bus.BVALID); end
    checks++; if (bus.BID !== 4'h0) begin errors++; $display("FAIL reset_bid: got %h required 0", bus.BID); end
    checks++; if (bus.BRESP !== 2'b00) begin errors++; $display("FAIL reset_bresp: got %b required 00", bus.BRESP); end
    exp_mem = '0;
    checks++;
    if (slave_mem !== exp_mem) begin
      errors++; idx = first_diff();
      $display("FAIL reset_mem: byte 0x%03h got %02h required %02h", idx, slave_mem[idx], exp_mem[idx]);
    end
    resetn = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_incr();
    logic [3:0] bid; logic [1:0] bresp; int idx;
    do_aw(4'h5, 32'h100, 4'd3, 3'd2, 2'b01);
    checks++; if (bus.AWREADY !== 1'b0) begin errors++; $display("FAIL incr_awready_busy: got %b required 0", bus.AWREADY); end
    checks++; if (bus.WREADY !== 1'b1) begin errors++; $display("FAIL incr_wready: got %b required 1", bus.WREADY); end
    do_w(4'h5, 32'h11111111, 4'hF, 1'b0);
    do_w(4'h5, 32'h22222222, 4'hF, 1'b0);
    do_w(4'h5, 32'h33333333, 4'hF, 1'b0);
    do_w(4'h5, 32'h44444444, 4'hF, 1'b1);
    w_idle();
    checks++; if (bus.BVALID !== 1'b1) begin errors++; $display("FAIL incr_bvalid_latency: got %b required 1", bus.BVALID); end
    set_word(32'h100, 32'h11111111); set_word(32'h104, 32'h22222222);
    set_word(32'h108, 32'h33333333); set_word(32'h10C, 32'h44444444);
    checks++;
    if (slave_mem !== exp_mem) begin
      errors++; idx = first_diff();
      $display("FAIL incr_mem: byte 0x%03h got %02h required %02h", idx, slave_mem[idx], exp_mem[idx]);
    end
    do_b(bid, bresp);
    checks++; if (bid !== 4'h5) begin errors++; $display("FAIL incr_bid: got %h required 5", bid); end
    checks++; if (bresp !== 2'b00) begin errors++; $display("FAIL incr_bresp: got %b required 00", bresp); end
    checks++; if (bus.AWREADY !== 1'b1) begin errors++; $display("FAIL incr_awready_after_b: got %b required 1", bus.AWREADY); end
  endtask

  task automatic test_wrap();
    logic [3:0] bid; logic [1:0] bresp; int idx;
    do_aw(4'h3, 32'h208, 4'd3, 3'd2, 2'b10);
    do_w(4'h3, 32'hA0A1A2A3, 4'hF, 1'b0);
    do_w(4'h3, 32'hB0B1B2B3, 4'hF, 1'b0);
    do_w(4'h3, 32'hC0C1C2C3, 4'hF, 1'b0);
    do_w(4'h3, 32'hD0D1D2D3, 4'hF, 1'b1);
    w_idle();
    set_word(32'h208, 32'hA0A1A2A3); set_word(32'h20C, 32'hB0B1B2B3);
    set_word(32'h200, 32'hC0C1C2C3); set_word(32'h204, 32'hD0D1D2D3);
    checks++;
    if (slave_mem !== exp_mem) begin
      errors++; idx = first_diff();
      $display("FAIL wrap_mem: byte 0x%03h got %02h required %02h", idx, slave_mem[idx], exp_mem[idx]);
    end
    do_b(bid, bresp);
    checks++; if (bresp !== 2'b00 || bid !== 4'h3) begin errors++; $display("FAIL wrap_b: got id %h resp %b required id 3 resp 00", bid, bresp); end
  endtask

  task automatic test_narrow();
    logic [3:0] bid; logic [1:0] bresp; int idx;
    do_aw(4'h1, 32'h301, 4'd3, 3'd0, 2'b01);
    for (int n = 0; n < 4; n++) do_w(4'h1, 32'h44332211, 4'hF, (n == 3));
    w_idle();
    exp_mem[12'h301] = 8'h22; exp_mem[12'h302] = 8'h33;
    exp_mem[12'h303] = 8'h44; exp_mem[12'h304] = 8'h11;
    checks++;
    if (slave_mem !== exp_mem) begin
      errors++; idx = first_diff();
      $display("FAIL narrow_mem: byte 0x%03h got %02h required %02h", idx, slave_mem[idx], exp_mem[idx]);
    end
    do_b(bid, bresp);
    checks++; if (bresp !== 2'b00) begin errors++; $display("FAIL narrow_bresp: got %b required 00", bresp); end
  endtask

  task automatic test_errors();
    logic [3:0] bid; logic [1:0] bresp; int idx;
    // reserved burst type: data dropped
    do_aw(4'h2, 32'h400, 4'd1, 3'd2, 2'b11);
    do_w(4'h2, 32'hFFFFFFFF, 4'hF, 1'b0);
    do_w(4'h2, 32'hFFFFFFFF, 4'hF, 1'b1);
    w_idle();
    checks++;
    if (slave_mem !== exp_mem) begin
      errors++; idx = first_diff();
      $display("FAIL err_burst_mem: byte 0x%03h got %02h required %02h", idx, slave_mem[idx], exp_mem[idx]);
    end
    do_b(bid, bresp);
    checks++; if (bresp !== 2'b10) begin errors++; $display("FAIL err_burst_bresp: got %b required 10", bresp); end
    // 8-byte beats on a 4-byte bus
    do_aw(4'h2, 32'h500, 4'd0, 3'd3, 2'b01);
    do_w(4'h2, 32'hEEEEEEEE, 4'hF, 1'b1);
    w_idle();
    do_b(bid, bresp);
    checks++; if (bresp !== 2'b10 || slave_mem[12'h500] !== 8'h00) begin errors++; $display("FAIL err_size: got resp %b byte %02h required resp 10 byte 00", bresp, slave_mem[12'h500]); end
    // WID mismatch on beat 2: still written
    do_aw(4'h6, 32'h600, 4'd3, 3'd2, 2'b01);
    do_w(4'h6, 32'h61616161, 4'hF, 1'b0);
    do_w(4'h6, 32'h62626262, 4'hF, 1'b0);
    do_w(4'h7, 32'h63636363, 4'hF, 1'b0);
    do_w(4'h6, 32'h64646464, 4'hF, 1'b1);
    w_idle();
    set_word(32'h600, 32'h61616161); set_word(32'h604, 32'h62626262);
    set_word(32'h608, 32'h63636363); set_word(32'h60C, 32'h64646464);
    checks++;
    if (slave_mem !== exp_mem) begin
      errors++; idx = first_diff();
      $display("FAIL wid_mem: byte 0x%03h got %02h required %02h", idx, slave_mem[idx], exp_mem[idx]);
    end
    do_b(bid, bresp);
    checks++; if (bresp !== 2'b10 || bid !== 4'h6) begin errors++; $display("FAIL wid_b: got id %h resp %b required id 6 resp 10", bid, bresp); end
    // early WLAST on beat 1 of a 4-beat burst
    do_aw(4'h2, 32'h700, 4'd3, 3'd2, 2'b01);
    do_w(4'h2, 32'h71717171, 4'hF, 1'b0);
    do_w(4'h2, 32'h72727272, 4'hF, 1'b1);
    w_idle();
    checks++; if (bus.BVALID !== 1'b1) begin errors++; $display("FAIL early_bvalid: got %b required 1", bus.BVALID); end
    do_b(bid, bresp);
    checks++; if (bresp !== 2'b10) begin errors++; $display("FAIL early_bresp: got %b required 10", bresp); end
    checks++; if (bus.AWREADY !== 1'b1) begin errors++; $display("FAIL early_idle: AWREADY got %b required 1", bus.AWREADY); end
    set_word(32'h700, 32'h71717171); set_word(32'h704, 32'h72727272);
    // late WLAST: extra beat dropped
    do_aw(4'h4, 32'h900, 4'd1, 3'd2, 2'b01);
    do_w(4'h4, 32'h91919191, 4'hF, 1'b0);
    do_w(4'h4, 32'h92929292, 4'hF, 1'b0);
    do_w(4'h4, 32'h93939393, 4'hF, 1'b1);
    w_idle();
    set_word(32'h900, 32'h91919191); set_word(32'h904, 32'h92929292);
    checks++;
    if (slave_mem !== exp_mem) begin
      errors++; idx = first_diff();
      $display("FAIL late_mem: byte 0x%03h got %02h required %02h", idx, slave_mem[idx], exp_mem[idx]);
    end
    do_b(bid, bresp);
    checks++; if (bresp !== 2'b10) begin errors++; $display("FAIL late_bresp: got %b required 10", bresp); end
  endtask

  task automatic test_addr_wrap();
    logic [3:0] bid; logic [1:0] bresp; int idx;
    do_aw(4'h8, 32'hFFC, 4'd1, 3'd2, 2'b01);
    do_w(4'h8, 32'hF3F2F1F0, 4'hF, 1'b0);
    do_w(4'h8, 32'h13121110, 4'hF, 1'b1);
    w_idle();
    set_word(32'hFFC, 32'hF3F2F1F0); set_word(32'h000, 32'h13121110);
    checks++;
    if (slave_mem !== exp_mem) begin
      errors++; idx = first_diff();
      $display("FAIL addr_wrap_mem: byte 0x%03h got %02h required %02h", idx, slave_mem[idx], exp_mem[idx]);
    end
    do_b(bid, bresp);
    checks++; if (bresp !== 2'b00) begin errors++; $display("FAIL addr_wrap_bresp: got %b required 00", bresp); end
  endtask

  task automatic test_backpressure();
    logic [3:0] bid; logic [1:0] bresp;
    do_aw(4'h9, 32'h800, 4'd0, 3'd2, 2'b01);
    do_w(4'h9, 32'h88888888, 4'hF, 1'b1);
    w_idle();
    set_word(32'h800, 32'h88888888);
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (bus.BVALID !== 1'b1 || bus.BID !== 4'h9 || bus.BRESP !== 2'b00 || bus.AWREADY !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold cycle %0d: got bvalid %b bid %h bresp %b awready %b required 1 9 00 0",
                 c, bus.BVALID, bus.BID, bus.BRESP, bus.AWREADY);
      end
      @(posedge clk); #1;
    end
    do_b(bid, bresp);
    checks++; if (bid !== 4'h9 || bresp !== 2'b00) begin errors++; $display("FAIL bp_b: got id %h resp %b required id 9 resp 00", bid, bresp); end
  endtask

  task automatic test_reset_mid();
    logic [3:0] bid; logic [1:0] bresp; int idx;
    do_aw(4'h1, 32'hA00, 4'd3, 3'd2, 2'b01);
    do_w(4'h1, 32'hAAAAAAAA, 4'hF, 1'b0);
    checks++; if (slave_mem[12'hA00] !== 8'hAA) begin errors++; $display("FAIL midrst_pre_write: got %02h required aa", slave_mem[12'hA00]); end
    #2 resetn = 1'b0;
    #1;
    exp_mem = '0;
    checks++;
    if (bus.AWREADY !== 1'b1 || bus.WREADY !== 1'b0 || bus.BVALID !== 1'b0) begin
      errors++;
      $display("FAIL midrst_outputs: got awready %b wready %b bvalid %b required 1 0 0", bus.AWREADY, bus.WREADY, bus.BVALID);
    end
    checks++;
    if (slave_mem !== exp_mem) begin
      errors++; idx = first_diff();
      $display("FAIL midrst_mem: byte 0x%03h got %02h required %02h", idx, slave_mem[idx], exp_mem[idx]);
    end
    w_idle();
    #3 resetn = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.BVALID !== 1'b0 || bus.AWREADY !== 1'b1) begin errors++; $display("FAIL midrst_no_b: got bvalid %b awready %b required 0 1", bus.BVALID, bus.AWREADY); end
    // FIXED burst after recovery
    do_aw(4'hC, 32'hB00, 4'd0, 3'd2, 2'b00);
    do_w(4'hC, 32'hCAFEF00D, 4'hF, 1'b1);
    w_idle();
    set_word(32'hB00, 32'hCAFEF00D);
    checks++;
    if (slave_mem !== exp_mem) begin
      errors++; idx = first_diff();
      $display("FAIL fixed_mem: byte 0x%03h got %02h required %02h", idx, slave_mem[idx], exp_mem[idx]);
    end
    do_b(bid, bresp);
    checks++; if (bid !== 4'hC || bresp !== 2'b00) begin errors++; $display("FAIL fixed_b: got id %h resp %b required id c resp 00", bid, bresp); end
  endtask

  initial begin
    resetn      = 1'b0;
    bus.AWID    = '0; bus.AWADDR = '0; bus.AWLEN = '0; bus.AWSIZE = '0;
    bus.AWBURST = '0; bus.AWVALID = 1'b0;
    bus.WID     = '0; bus.WDATA = '0; bus.WSTRB = '0; bus.WLAST = 1'b0; bus.WVALID = 1'b0;
    bus.BREADY  = 1'b0;
    exp_mem     = '0;
    test_reset();
    test_incr();
    test_wrap();
    test_narrow();
    test_errors();
    test_addr_wrap();
    test_backpressure();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/axi_slave_write_ctrl.md
Name: axi_slave_write_ctrl

Overview:
AXI3 write-channel slave for the verification top. It consumes the AW, W and B channels driven by the master side of the shared AXI interface. It decodes the burst type, writes the accepted bytes into a 4 KiB byte-addressed slave memory, and returns one write response per burst. The memory contents are exported as a packed array so the scoreboard can compare them directly against the master memory.

Parameters:
WIDTH, 32, data bus width in bits; must be 32 or 64; NB = WIDTH/8 byte lanes.
SIZE, 3, AxSIZE field width in bits.
ID_W, 4, AWID/WID/BID width in bits.
MEM_BYTES, 4096, slave memory depth in bytes; addresses wrap modulo MEM_BYTES.

Ports:
clk  in  1  system clock, rising-edge.
resetn  in  1  asynchronous active-low reset.
AWID  in  ID_W  write address ID.
AWADDR  in  32  burst start byte address.
AWLEN  in  4  beats minus 1 (AXI3).
AWSIZE  in  SIZE  bytes per beat = 2^AWSIZE.
AWBURST  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved.
AWVALID  in  1  address valid.
AWREADY  out  1  address accept.
WID  in  ID_W  write data ID.
WDATA  in  WIDTH  write data.
WSTRB  in  NB  byte strobes.
WLAST  in  1  last beat marker.
WVALID  in  1  data valid.
WREADY  out  1  data accept.
BID  out  ID_W  response ID.
BRESP  out  2  00 OKAY, 10 SLVERR.
BVALID  out  1  response valid.
BREADY  in  1  response accept.
slave_mem  out  MEM_BYTES*8  packed [MEM_BYTES-1:0][7:0] memory image.

Behaviour:
- Reset (async assert, sync release): state IDLE; AWREADY=1, WREADY=0, BVALID=0, BID=0, BRESP=00; all memory bytes 0. Reset mid-burst abandons the burst; no B response is issued.
- FSM has three states: IDLE, DATA, RESP.
- IDLE: AWREADY=1. On AWVALID&AWREADY, capture AWID/AWADDR/AWLEN/AWSIZE/AWBURST, clear the beat counter and error flag, go to DATA. AWREADY=0 on the next cycle.
- DATA: WREADY=1. Each W handshake writes memory; the written data is visible on slave_mem after that clock edge. The beat counter increments.
  - On a handshake with WLAST=1, go to RESP.
- RESP: BVALID=1, BID=captured AWID, BRESP held stable until BREADY. On BVALID&BREADY go to IDLE; AWREADY=1 on the following cycle. AW is never accepted while a burst is open.
- Error is decided at AW capture; the burst sets err and all of its data is discarded (no memory writes) when any of these hold:
  - AWBURST=11.
  - 2^AWSIZE > NB.
  - WRAP with AWLEN not in {1,3,7,15}.
  - WRAP with AWADDR not aligned to 2^AWSIZE.
- Per-beat errors set err, and that beat is still written if the burst is otherwise legal:
  - WID != captured AWID.
  - WLAST=1 before beat AWLEN (early: burst ends, go to RESP).
  - WLAST=0 on beat AWLEN (late: the counter saturates, extra beats are accepted and discarded until WLAST).
- BRESP = err ? 10 : 00.
- Beat address A(n), with S = 2^AWSIZE and L = AWLEN+1:
  - FIXED: A(n) = AWADDR.
  - INCR: A(0) = AWADDR; A(n) = (AWADDR & ~(S-1)) + n*S.
  - WRAP: B = AWADDR & ~(S*L-1); A(n) = B + ((AWADDR - B + n*S) mod (S*L)).
  - All addresses are taken modulo MEM_BYTES (silent wrap at 4096, no error).
- Lane rule:
  - Byte lane k is written to (A(n) & ~(NB-1)) + k when WSTRB[k]=1 and k lies in the active window.
  - The active window runs from lane A(n) mod NB up to, but not including, lane ((A(n) & ~(S-1)) mod NB) + S.
  - Strobes outside the active window are ignored.
- Throughput: one beat per cycle when WVALID is held high. Minimum burst cost is 1 (AW) + L (W) + 1 (B) cycles.

Test Plan:
- INCR, AWADDR=0x100, AWLEN=3, AWSIZE=2, WSTRB=F, data 0x11111111..0x44444444 -> bytes 0x100..0x10F written; BRESP=00; BID=AWID; BVALID 1 cycle after last beat.
- WRAP, AWADDR=0x208, AWLEN=3, AWSIZE=2 -> beats land at 0x208, 0x20C, 0x200, 0x204; BRESP=00.
- Narrow unaligned INCR, AWADDR=0x301, AWSIZE=0, AWLEN=3, WSTRB=F each beat -> only bytes 0x301..0x304 change (one per beat); all neighbouring bytes unchanged.
- Error cases:
  - AWBURST=11 -> no memory change, BRESP=10.
  - WID mismatch on beat 2 of an INCR burst -> data written, BRESP=10.
  - WLAST on beat 1 of AWLEN=3 -> BRESP=10, FSM returns to IDLE.
- INCR, AWADDR=0xFFC, AWLEN=1, AWSIZE=2 -> second beat lands at 0x000.
- Backpressure and reset:
  - BREADY held low 5 cycles -> BVALID/BID/BRESP stable, AWREADY=0 until B handshake.
  - Assert resetn low mid-DATA -> outputs return to reset values immediately; memory cleared.
